// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and colour-bar table for vga_timing_gen.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RESYNC    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_COLOR_W     = 8;
  localparam int DEF_LOCK_CYCLES = 256;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // {R,G,B} on/off mask per bar: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] mask;
    case (idx)
      3'd0:    mask = 3'b111;
      3'd1:    mask = 3'b110;
      3'd2:    mask = 3'b011;
      3'd3:    mask = 3'b010;
      3'd4:    mask = 3'b101;
      3'd5:    mask = 3'b100;
      3'd6:    mask = 3'b001;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/vga_timing_gen_lock_qual.sv
// PLL lock qualifier: 2-flop synchronizer plus a stable-count that restarts on any low sample.
module vga_lock_qual
  import vga_timing_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // lock_ok rises on the LOCK_CYCLES-th consecutive high sample of sync2
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign lock_ok = sync2 && (cnt == CNT_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator fed by a ready/valid pixel stream with SOP frame alignment.
// Optional colour-bar fill for starved/unaligned pixels: VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic [3*COLOR_W-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic                 in_ready,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic                 underflow
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_t               state;
  state_t               state_nx;
  logic                 lock_ok;
  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic                 active;
  logic                 at_origin;
  logic                 at_end;
  logic                 fire;
  logic                 show;
  logic                 hold;
  logic [3*COLOR_W-1:0] fill;
  logic [3*COLOR_W-1:0] color_d;
  logic                 hs_d;
  logic                 vs_d;
  logic                 underflow_d;

  vga_lock_qual #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_qual (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .lock_ok   (lock_ok)
  );

  // Loss of lock and reset share one path: counters and outputs return to idle
  assign hold = rst || !lock_ok || (state == WAIT_LOCK);

  always_ff @(posedge clk) begin
    if (hold) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    active    = (h < H_ACT_END) && (v < V_ACT_END);
    at_origin = (h == '0) && (v == '0);
    at_end    = (h == H_LAST) && (v == V_LAST);
    hs_d      = !((h >= HS_START) && (h < HS_END));
    vs_d      = !((v >= VS_START) && (v < VS_END));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_ok) state_nx = RESYNC;
      end
      RESYNC: begin
        // Non-SOP beats are drained; an SOP beat waits for the frame boundary
        in_ready = !in_sop;
        if (at_end && in_valid && in_sop) state_nx = RUN;
      end
      RUN: begin
        in_ready = active && !(in_sop && !at_origin);
        if (active && in_valid && (in_sop != at_origin)) state_nx = RESYNC;
      end
      default: state_nx = WAIT_LOCK;
    endcase
    if (!lock_ok) state_nx = WAIT_LOCK;
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic [2:0] bar_mask;

  always_comb begin
    bar_idx  = 3'(h / HW'(BAR_W));
    bar_mask = bar_rgb(bar_idx);
    fill     = {{COLOR_W{bar_mask[2]}}, {COLOR_W{bar_mask[1]}}, {COLOR_W{bar_mask[0]}}};
  end
`else
  assign fill = '0;
`endif

  always_comb begin
    fire        = in_valid && in_ready;
    show        = (state == RUN) && fire && (in_sop || !at_origin);
    underflow_d = (state == RUN) && active && !in_valid;
    if (!active) begin
      color_d = '0;
    end else if (show) begin
      color_d = in_data;
    end else begin
      color_d = fill;
    end
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vga_r       <= color_d[3*COLOR_W-1:2*COLOR_W];
      vga_g       <= color_d[2*COLOR_W-1:COLOR_W];
      vga_b       <= color_d[COLOR_W-1:0];
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      vga_blank_n <= active;
      underflow   <= underflow_d;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x8 raster (24x13 totals).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA = 16;
  localparam int HT = 24;
  localparam int VA = 8;
  localparam int VT = 13;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_ready;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_sync_n;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  int         sx;
  int         sy;
  logic [7:0] tag;
  bit         src_en;
  bit         drop_now;
  logic       last_ready;

  always #20 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .COLOR_W(8), .LOCK_CYCLES(256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_ready   (in_ready),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n (vga_sync_n),
    .underflow  (underflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] fill(input int x);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] m;
    case (x / 2)
      0:       m = 3'b111;
      1:       m = 3'b110;
      2:       m = 3'b011;
      3:       m = 3'b010;
      4:       m = 3'b101;
      5:       m = 3'b100;
      6:       m = 3'b001;
      default: m = 3'b000;
    endcase
    return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
`else
    return (x < 0) ? 24'h0 : 24'h0;
`endif
  endfunction

  // One pixel clock: drive at negedge, note handshake, advance source, settle past posedge
  task automatic tick();
    bit adv;
    @(negedge clk);
    in_valid = src_en && !drop_now;
    in_data  = {8'(sx), 8'(sy), tag};
    in_sop   = src_en && (sx == 0) && (sy == 0);
    #1;
    last_ready = in_ready;
    adv = (in_valid && in_ready) || (src_en && drop_now);
    @(posedge clk);
    if (adv) begin
      sx++;
      if (sx == HA) begin
        sx = 0;
        sy++;
        if (sy == VA) sy = 0;
      end
    end
    #1;
  endtask

  task automatic wait_state(input state_t s, input int bound, output int n);
    n = 0;
    while (dut.state != s && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_hs"}, vga_hs, 1);
    check({name, "_vs"}, vga_vs, 1);
    check({name, "_blank_n"}, vga_blank_n, 0);
    check({name, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({name, "_ready"}, in_ready, 0);
    check({name, "_underflow"}, underflow, 0);
    check({name, "_sync_n"}, vga_sync_n, 0);
    check({name, "_state"}, dut.state, WAIT_LOCK);
    check({name, "_h"}, dut.h, 0);
    check({name, "_v"}, dut.v, 0);
  endtask

  task automatic run_frame(input bit run, input int dx, input int dy, input int dn,
                           output int errs, output int blanks, output int ufs,
                           output int hs_lo, output int vs_lo, output logic [23:0] first);
    errs = 0; blanks = 0; ufs = 0; hs_lo = 0; vs_lo = 0; first = '0;
    for (int n = 0; n < FRAME; n++) begin
      int x;
      int y;
      bit act;
      bit drop;
      logic [23:0] exp_rgb;
      x = n % HT;
      y = n / HT;
      act  = (x < HA) && (y < VA);
      drop = run && (y == dy) && (x >= dx) && (x < dx + dn);
      drop_now = drop;
      tick();
      drop_now = 1'b0;
      if (!act) exp_rgb = '0;
      else if (run && !drop) exp_rgb = {8'(x), 8'(y), tag};
      else exp_rgb = fill(x);
      if (n == 0) first = {vga_r, vga_g, vga_b};
      if ({vga_r, vga_g, vga_b} !== exp_rgb || vga_blank_n !== act ||
          vga_hs !== !(x >= 18 && x < 21) || vga_vs !== !(y >= 9 && y < 11) ||
          underflow !== (run && act && drop)) errs++;
      if (vga_blank_n) blanks++;
      if (underflow) ufs++;
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
    end
  endtask

  initial begin
    int n;
    int errs, blanks, ufs, hs_lo, vs_lo;
    logic [23:0] first;

    rst = 1'b1; pll_locked = 1'b0;
    src_en = 1'b0; drop_now = 1'b0; sx = 0; sy = 0; tag = 8'h5A;
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0;
    repeat (2) tick();
    check_reset("por");

    rst = 1'b0;
    tick();
    check("nolock_state", dut.state, WAIT_LOCK);

    pll_locked = 1'b1;
    wait_state(RESYNC, 400, n);
    check("lock_to_resync", n, 258);
    check("resync_ready_idle", in_ready, 1);

    run_frame(1'b0, -1, -1, 0, errs, blanks, ufs, hs_lo, vs_lo, first);
    check("resync_frame_errs", errs, 0);
    check("resync_hs_low", hs_lo, 3 * VT);
    check("resync_vs_low", vs_lo, 2 * HT);
    check("resync_blank_n_high", blanks, HA * VA);

    src_en = 1'b1;
    wait_state(RUN, 400, n);
    check("resync_to_run", n, FRAME);

    run_frame(1'b1, -1, -1, 0, errs, blanks, ufs, hs_lo, vs_lo, first);
    check("run_frame_errs", errs, 0);
    check("run_first_pixel", first, 24'h00005A);
    check("run_blank_n_high", blanks, HA * VA);
    check("run_underflows", ufs, 0);

    run_frame(1'b1, 2, 3, 3, errs, blanks, ufs, hs_lo, vs_lo, first);
    check("starve_frame_errs", errs, 0);
    check("starve_underflows", ufs, 3);
    check("starve_state", dut.state, RUN);

    // Misplaced SOP at (10,5): held beat must open the following frame
    repeat (5 * HT + 10) tick();
    sx = 0; sy = 0; tag = 8'hA5;
    tick();
    check("sop_ready", last_ready, 0);
    check("sop_state", dut.state, RESYNC);
    check("sop_pixel", {vga_r, vga_g, vga_b}, fill(10));
    check("sop_underflow", underflow, 0);
    wait_state(RUN, 400, n);
    check("sop_to_run", n, FRAME - (5 * HT + 11));
    run_frame(1'b1, -1, -1, 0, errs, blanks, ufs, hs_lo, vs_lo, first);
    check("realign_frame_errs", errs, 0);
    check("realign_first_pixel", first, 24'h0000A5);

    repeat (50) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    check_reset("unlock");

    src_en = 1'b0; sx = 0; sy = 0; tag = 8'h5A;
    pll_locked = 1'b1;
    wait_state(RESYNC, 400, n);
    check("relock_to_resync", n, 258);
    src_en = 1'b1;
    wait_state(RUN, 400, n);
    check("relock_to_run", n, FRAME);
    run_frame(1'b1, -1, -1, 0, errs, blanks, ufs, hs_lo, vs_lo, first);
    check("relock_frame_errs", errs, 0);

    repeat (40) tick();
    rst = 1'b1;
    tick();
    check_reset("rst");
    rst = 1'b0;
    wait_state(RESYNC, 400, n);
    check("rst_to_resync", n, 258);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
